// File: rtl/wvb_readout_pkg.sv
// Shared types and constants for the waveform-buffer readout controller.
package wvb_readout_pkg;

    // Width of one word on the outgoing packet stream.
    localparam int STREAM_W = 32;

    // Header field positions, in units of the buffer address width.
    localparam int START_FIELD = 0;
    localparam int STOP_FIELD  = 1;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        HDR,
        SAMP,
        DRAIN
    } state_t;

    // Number of stream words needed to carry a field of the given width.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/wvb_readout_if.sv
// 32-bit valid/ready packet stream toward the DMA/readout FIFO.
interface wvb_readout_if;
    import wvb_readout_pkg::*;

    logic [STREAM_W-1:0] dout;
    logic                dout_valid;
    logic                dout_last;
    logic                dout_ready;

    modport master (output dout, dout_valid, dout_last, input dout_ready);
    modport slave  (input dout, dout_valid, dout_last, output dout_ready);

endinterface

// File: rtl/wvb_ofifo.sv
// Show-ahead synchronous FIFO with occupancy count; pushes while full are dropped.
module wvb_ofifo #(
    parameter int P_DEPTH = 8,
    parameter int P_WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [P_WIDTH-1:0]         din,
    input  logic                       pop,
    output logic [P_WIDTH-1:0]         dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(P_DEPTH):0]   count
);

    localparam int AW = $clog2(P_DEPTH);

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == (AW + 1)'(P_DEPTH));
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage write.
    // NOTE: the data array has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; extra MSB distinguishes full from empty.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/wvb_readout_ctrl.sv
// Pops a header and its samples from the waveform buffer and serializes them
// into a 32-bit packet stream, issuing sample reads only against free FIFO credit.
module wvb_readout_ctrl
    import wvb_readout_pkg::*;
#(
    parameter int P_DATA_WIDTH  = 28,
    parameter int P_ADR_WIDTH   = 15,
    parameter int P_HDR_WIDTH   = 87,
    parameter int P_RD_LATENCY  = 2,
    parameter int P_OFIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    hdr_empty,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data_out,
    output logic                    hdr_rdreq,
    input  logic [P_DATA_WIDTH-1:0] wvb_data_out,
    output logic                    wvb_rdreq,
    output logic                    wvb_rddone,
    wvb_readout_if.master           strm,
    output logic                    busy,
    output logic [15:0]             pkt_cnt
);

    localparam int NH        = ceil_div(P_HDR_WIDTH, STREAM_W);
    localparam int HDR_PAD_W = NH * STREAM_W;
    localparam int IDX_W     = $clog2(NH) + 1;
    localparam int CNT_W     = $clog2(P_OFIFO_DEPTH) + 1;
    localparam int FL_W      = $clog2(P_RD_LATENCY + 1);
    localparam int N_W       = P_ADR_WIDTH + 1;
    localparam int FIFO_W    = STREAM_W + 1;

    state_t                  state_q, state_d;
    logic [HDR_PAD_W-1:0]    hdr_q;
    logic [HDR_PAD_W-1:0]    hdr_in_pad;
    logic [N_W-1:0]          n_q, n_d;
    logic [IDX_W-1:0]        hdr_idx_q;
    logic [N_W-1:0]          issued_q;
    logic [N_W-1:0]          ret_cnt_q;
    logic [FL_W-1:0]         in_flight_q;
    logic [P_RD_LATENCY-1:0] dl_q;
    logic [P_ADR_WIDTH-1:0]  start_addr, stop_addr, span;

    logic                    ret_valid, ret_last, credit_ok;
    logic                    fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [FIFO_W-1:0]       fifo_din, fifo_dout;
    logic [CNT_W-1:0]        fifo_count;

    assign hdr_in_pad = HDR_PAD_W'(hdr_data_out);
    assign start_addr = hdr_data_out[START_FIELD*P_ADR_WIDTH +: P_ADR_WIDTH];
    assign stop_addr  = hdr_data_out[STOP_FIELD*P_ADR_WIDTH +: P_ADR_WIDTH];
    assign span       = stop_addr - start_addr + P_ADR_WIDTH'(1);
    // A span that wraps to zero is a full-buffer waveform, hence the extra bit.
    assign n_d        = (span == '0) ? {1'b1, span} : {1'b0, span};

    assign ret_valid  = dl_q[P_RD_LATENCY-1];
    assign ret_last   = (ret_cnt_q == n_q - N_W'(1));
    // In-flight reads hold a reserved slot, so returns can never overflow the FIFO.
    assign credit_ok  = (int'(fifo_count) + int'(in_flight_q)) < P_OFIFO_DEPTH;
    assign busy       = (state_q != IDLE);

    // Next-state, handshake pulses and FIFO push source.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        hdr_rdreq  = 1'b0;
        wvb_rdreq  = 1'b0;
        wvb_rddone = 1'b0;
        fifo_push  = 1'b0;
        fifo_din   = '0;
        case (state_q)
            IDLE: begin
                if (en && !hdr_empty) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                // Header word 0 goes straight from the show-ahead bus so it is
                // valid one cycle after hdr_rdreq; the FIFO is empty here.
                hdr_rdreq = 1'b1;
                fifo_push = 1'b1;
                fifo_din  = {1'b0, hdr_in_pad[STREAM_W-1:0]};
                state_d   = (NH == 1) ? SAMP : HDR;
            end
            HDR: begin
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    fifo_din  = {1'b0, hdr_q[STREAM_W*hdr_idx_q +: STREAM_W]};
                    if (hdr_idx_q == IDX_W'(NH - 1)) begin
                        state_d = SAMP;
                    end
                end
            end
            SAMP: begin
                if (issued_q < n_q && credit_ok) begin
                    wvb_rdreq = 1'b1;
                    if (issued_q == n_q - N_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (in_flight_q == '0 && fifo_count == '0) begin
                    wvb_rddone = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Sample returns only occur in SAMP/DRAIN, never alongside header pushes.
        if (ret_valid) begin
            fifo_push = 1'b1;
            fifo_din  = {ret_last, STREAM_W'(wvb_data_out)};
        end
    end

    // State register plus per-packet counters and the read-return delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hdr_q       <= '0;
            n_q         <= '0;
            hdr_idx_q   <= '0;
            issued_q    <= '0;
            ret_cnt_q   <= '0;
            in_flight_q <= '0;
            dl_q        <= '0;
            pkt_cnt     <= '0;
        end else begin
            state_q <= state_d;
            dl_q    <= (dl_q << 1) | P_RD_LATENCY'(wvb_rdreq);
            if (state_q == LATCH) begin
                hdr_q     <= hdr_in_pad;
                n_q       <= n_d;
                hdr_idx_q <= IDX_W'(1);
                issued_q  <= '0;
                ret_cnt_q <= '0;
            end
            if (state_q == HDR && !fifo_full) begin
                hdr_idx_q <= hdr_idx_q + IDX_W'(1);
            end
            if (wvb_rdreq) begin
                issued_q <= issued_q + N_W'(1);
            end
            if (ret_valid) begin
                ret_cnt_q <= ret_cnt_q + N_W'(1);
            end
            case ({wvb_rdreq, ret_valid})
                2'b10:   in_flight_q <= in_flight_q + FL_W'(1);
                2'b01:   in_flight_q <= in_flight_q - FL_W'(1);
                default: ;
            endcase
            if (wvb_rddone) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

    assign fifo_pop = strm.dout_valid && strm.dout_ready;

    wvb_ofifo #(
        .P_DEPTH (P_OFIFO_DEPTH),
        .P_WIDTH (FIFO_W)
    ) u_ofifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Head of the FIFO drives the stream; masked while empty so outputs read zero.
    assign strm.dout       = fifo_empty ? '0 : fifo_dout[STREAM_W-1:0];
    assign strm.dout_valid = !fifo_empty;
    assign strm.dout_last  = !fifo_empty && fifo_dout[STREAM_W];

endmodule

// File: tb/tb_wvb_readout_ctrl.sv
// Bench for wvb_readout_ctrl: waveform-buffer model, stream scoreboard,
// table-driven packets and hand-written backpressure/back-to-back/reset sequences.
module tb_wvb_readout_ctrl;

    localparam int NH            = 3;
    localparam int P_OFIFO_DEPTH = 8;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [14:0] start;
        logic [14:0] stop;
        int          n;
        int          words;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        hdr_empty;
    logic [86:0] hdr_data_out;
    logic        hdr_rdreq;
    logic [27:0] wvb_data_out;
    logic        wvb_rdreq;
    logic        wvb_rddone;
    logic        busy;
    logic [15:0] pkt_cnt;

    wvb_readout_if strm ();

    wvb_readout_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .hdr_empty    (hdr_empty),
        .hdr_data_out (hdr_data_out),
        .hdr_rdreq    (hdr_rdreq),
        .wvb_data_out (wvb_data_out),
        .wvb_rdreq    (wvb_rdreq),
        .wvb_rddone   (wvb_rddone),
        .strm         (strm),
        .busy         (busy),
        .pkt_cnt      (pkt_cnt)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   exp_pkts = 0;
    logic bp_on    = 1'b0;

    // Monitor counters (written only by the monitor).
    int   n_rd = 0, n_words = 0, n_hdr = 0, n_rddone = 0;
    int   pkt_rd = 0, pkt_words = 0, max_out = 0;
    logic pkt_open = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- waveform buffer model ----------------
    logic [86:0] hdr_mem [32];
    int          wr_n = 0;
    int          rd_n = 0;
    logic [14:0] rd_addr = '0, pipe1 = '0, pipe2 = '0;

    function automatic logic [27:0] samp_val(input logic [14:0] a);
        return {~a[12:0], a};
    endfunction

    assign hdr_empty    = (wr_n == rd_n);
    assign hdr_data_out = hdr_mem[rd_n[4:0]];
    // Two-stage address pipe: data for a read appears two cycles after its rdreq.
    assign wvb_data_out = samp_val(pipe2);

    always @(posedge clk) begin
        if (hdr_rdreq) begin
            rd_addr <= hdr_data_out[14:0];
            rd_n    <= rd_n + 1;
        end else if (wvb_rdreq) begin
            rd_addr <= rd_addr + 15'd1;
        end
        pipe1 <= rd_addr;
        pipe2 <= pipe1;
    end

    // Downstream ready: always high, or about 30% duty when backpressure is on.
    initial begin
        strm.dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            strm.dout_ready = bp_on ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // ---------------- stream monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            pkt_open <= 1'b0;
        end else begin
            if (wvb_rdreq) begin
                check("credit_no_overflow", (pkt_rd + NH - pkt_words + 1) <= P_OFIFO_DEPTH, 1'b1);
                if (pkt_rd + NH - pkt_words + 1 > max_out) max_out <= pkt_rd + NH - pkt_words + 1;
                pkt_rd <= pkt_rd + 1;
                n_rd   <= n_rd + 1;
            end
            if (strm.dout_valid && strm.dout_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word_valid", strm.dout_valid, 1'b0);
                end else begin
                    check("word_data", strm.dout, exp_q[0].data);
                    check("word_last", strm.dout_last, exp_q[0].last);
                    void'(exp_q.pop_front());
                end
                pkt_words <= pkt_words + 1;
                n_words   <= n_words + 1;
            end
            if (hdr_rdreq) begin
                check("hdr_rdreq_after_rddone", pkt_open, 1'b0);
                pkt_open  <= 1'b1;
                n_hdr     <= n_hdr + 1;
                pkt_rd    <= 0;
                pkt_words <= 0;
            end
            if (wvb_rddone) begin
                check("rddone_after_last_word", pkt_words, pkt_rd + NH);
                pkt_open <= 1'b0;
                n_rddone <= n_rddone + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_hdr(input logic [14:0] start, input logic [14:0] stop, input int n);
        logic [95:0] raw;
        logic [86:0] h;
        logic [95:0] pad;
        logic [14:0] a;
        raw = {$urandom, $urandom, $urandom};
        h = raw[86:0];
        h[14:0]  = start;
        h[29:15] = stop;
        hdr_mem[wr_n[4:0]] = h;
        wr_n++;
        pad = {9'b0, h};
        for (int k = 0; k < NH; k++) exp_q.push_back('{data: pad[32*k +: 32], last: 1'b0});
        for (int i = 0; i < n; i++) begin
            a = start + 15'(i);
            exp_q.push_back('{data: {4'b0, samp_val(a)}, last: (i == n - 1)});
        end
    endtask

    // which: 0 = rddone count, 1 = hdr_rdreq count, 2 = rdreq count.
    task automatic wait_cnt(input int which, input int target, input int budget);
        int v;
        v = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            v = (which == 0) ? n_rddone : (which == 1) ? n_hdr : n_rd;
            if (v >= target) return;
        end
        check($sformatf("wait_timeout_%0d", which), v, target);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("idle_timeout_busy", busy, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        int b_hdr, b_rd, b_w, b_done;
        wait_idle(5000);
        b_hdr = n_hdr; b_rd = n_rd; b_w = n_words; b_done = n_rddone;
        push_hdr(v.start, v.stop, v.n);
        @(negedge clk);
        check("hdr_rdreq_latency", hdr_rdreq, 1'b1);
        @(negedge clk);
        check("first_word_latency", strm.dout_valid, 1'b1);
        wait_cnt(0, b_done + 1, 2000);
        @(negedge clk);
        exp_pkts++;
        check("n_hdr_rdreq", n_hdr - b_hdr, 1);
        check("n_wvb_rdreq", n_rd - b_rd, v.n);
        check("n_words", n_words - b_w, v.words);
        check("n_rddone", n_rddone - b_done, 1);
        check("pkt_cnt", pkt_cnt, exp_pkts);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs [4];

    initial begin
        int b_hdr, b_rd, b_w, b_done;
        vecs[0] = '{start: 15'd10,    stop: 15'd13,    n: 4,  words: 7};
        vecs[1] = '{start: 15'd32766, stop: 15'd1,     n: 4,  words: 7};
        vecs[2] = '{start: 15'd5,     stop: 15'd5,     n: 1,  words: 4};
        vecs[3] = '{start: 15'd0,     stop: 15'd31,    n: 32, words: 35};

        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout_valid", strm.dout_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pkt_cnt", pkt_cnt, 16'd0);
        check("rst_hdr_rdreq", hdr_rdreq, 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Backpressure: 30% ready, 100 samples; reads must stall on credit.
        wait_idle(5000);
        b_rd = n_rd; b_w = n_words; b_done = n_rddone;
        bp_on = 1'b1;
        push_hdr(15'd200, 15'd299, 100);
        wait_cnt(0, b_done + 1, 20000);
        bp_on = 1'b0;
        @(negedge clk);
        exp_pkts++;
        check("bp_n_words", n_words - b_w, 103);
        check("bp_n_rdreq", n_rd - b_rd, 100);
        check("bp_credit_limit_reached", max_out, P_OFIFO_DEPTH);
        check("bp_pkt_cnt", pkt_cnt, exp_pkts);
        check("bp_scoreboard_drained", exp_q.size(), 0);

        // Back-to-back: three queued headers.
        wait_idle(5000);
        b_hdr = n_hdr; b_done = n_rddone;
        push_hdr(15'd1000, 15'd1002, 3);
        push_hdr(15'd2000, 15'd2009, 10);
        push_hdr(15'd3000, 15'd3000, 1);
        wait_cnt(0, b_done + 3, 3000);
        @(negedge clk);
        exp_pkts += 3;
        check("b2b_n_hdr_rdreq", n_hdr - b_hdr, 3);
        check("b2b_pkt_cnt", pkt_cnt, exp_pkts);
        check("b2b_scoreboard_drained", exp_q.size(), 0);

        // en dropped after the first packet starts: only that packet completes.
        wait_idle(5000);
        b_hdr = n_hdr; b_done = n_rddone;
        push_hdr(15'd4000, 15'd4005, 6);
        push_hdr(15'd5000, 15'd5001, 2);
        push_hdr(15'd6000, 15'd6003, 4);
        wait_cnt(1, b_hdr + 1, 100);
        @(negedge clk);
        en = 1'b0;
        wait_cnt(0, b_done + 1, 2000);
        repeat (30) @(negedge clk);
        exp_pkts++;
        check("en_off_n_rddone", n_rddone - b_done, 1);
        check("en_off_n_hdr_rdreq", n_hdr - b_hdr, 1);
        check("en_off_busy", busy, 1'b0);
        check("en_off_pkt_cnt", pkt_cnt, exp_pkts);
        en = 1'b1;
        wait_cnt(0, b_done + 3, 2000);
        @(negedge clk);
        exp_pkts += 2;
        check("en_on_pkt_cnt", pkt_cnt, exp_pkts);
        check("en_on_scoreboard_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of SAMP.
        wait_idle(5000);
        b_rd = n_rd;
        push_hdr(15'd100, 15'd119, 20);
        wait_cnt(2, b_rd + 5, 200);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_dout", strm.dout, 32'd0);
        check("arst_dout_valid", strm.dout_valid, 1'b0);
        check("arst_dout_last", strm.dout_last, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_pkt_cnt", pkt_cnt, 16'd0);
        check("arst_hdr_rdreq", hdr_rdreq, 1'b0);
        check("arst_wvb_rdreq", wvb_rdreq, 1'b0);
        check("arst_wvb_rddone", wvb_rddone, 1'b0);
        exp_q.delete();
        exp_pkts = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_dout_valid", strm.dout_valid, 1'b0);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
